// File: rtl/uart_bram_writer.sv
`default_nettype none
// ============================================================================
// uart_bram_writer - writes one UART-received frame into sequential BRAM
// addresses. Optional trailing checksum byte: UART_BRAM_WRITER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module uart_bram_writer #(
  parameter int IMAGE_DEPTH = 49284,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [15:0]       image_write_count,
  output logic              bram_write_complete,
  output logic              overrun_error,
  output logic              checksum_error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    WRITE     = 3'd2,
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    CHECK     = 3'd3,
`endif
    DONE      = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_count;
  logic              last_pixel;

  assign last_pixel          = (addr_count == LAST_ADDR);
  assign bram_write_complete = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (rx_valid) state_next = WRITE;
      end
      WRITE: begin
        if (last_pixel) begin
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = WAIT_BYTE;
        end
      end
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) state_next = DONE;
      end
`endif
      DONE: begin
        if (start) state_next = WAIT_BYTE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data registers are only loaded on accept so they hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bram_we           <= 1'b0;
      bram_addr         <= '0;
      bram_din          <= '0;
      addr_count        <= '0;
      image_write_count <= '0;
      overrun_error     <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr_count        <= '0;
            image_write_count <= '0;
            overrun_error     <= 1'b0;
          end
        end
        WAIT_BYTE: begin
          if (rx_valid) begin
            bram_we   <= 1'b1;
            bram_addr <= addr_count;
            bram_din  <= rx_data;
          end
        end
        WRITE: begin
          addr_count        <= addr_count + ADDR_W'(1);
          image_write_count <= image_write_count + 16'd1;
          if (rx_valid) overrun_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_BRAM_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_acc   <= '0;
      checksum_error <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum_acc   <= '0;
            checksum_error <= 1'b0;
          end
        end
        WAIT_BYTE: begin
          if (rx_valid) checksum_acc <= checksum_acc + rx_data;
        end
        CHECK: begin
          if (rx_valid) checksum_error <= (rx_data != checksum_acc);
        end
        default: ;
      endcase
    end
  end
`else
  assign checksum_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_bram_writer.sv
`default_nettype none
// Bench for uart_bram_writer (IMAGE_DEPTH=4): directed literal checks plus
// randomized frames compared every cycle against a frame-level model.
module tb_uart_bram_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_din;
  logic [15:0] image_write_count;
  logic        bram_write_complete;
  logic        overrun_error;
  logic        checksum_error;

  int tests = 0;
  int fails = 0;

  uart_bram_writer #(
    .IMAGE_DEPTH (DEPTH),
    .ADDR_W      (16),
    .DATA_W      (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .bram_we             (bram_we),
    .bram_addr           (bram_addr),
    .bram_din            (bram_din),
    .image_write_count   (image_write_count),
    .bram_write_complete (bram_write_complete),
    .overrun_error       (overrun_error),
    .checksum_error      (checksum_error)
  );

  always #5 clk = ~clk;

  logic [43:0] outvec;
  assign outvec = {bram_we, bram_addr, bram_din, image_write_count,
                   bram_write_complete, overrun_error, checksum_error};

  // Frame-level model: counts accepted pixels and tracks the one-cycle busy gap.
  bit          m_armed, m_done, m_gap, m_cswait, m_we, m_over, m_cserr;
  int          m_nacc;
  logic [15:0] m_wcount, m_addr;
  logic [7:0]  m_din, m_sum;
  logic [43:0] expvec;
  assign expvec = {m_we, m_addr, m_din, m_wcount, m_done, m_over, m_cserr};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_armed = 0; m_done = 0; m_gap = 0; m_cswait = 0; m_we = 0;
      m_over = 0; m_cserr = 0; m_nacc = 0; m_wcount = 0; m_addr = 0;
      m_din = 0; m_sum = 0;
    end else begin
      m_we = 0;
      if (m_gap) begin
        m_gap = 0;
        m_wcount = 16'(m_nacc);
        if (rx_valid) m_over = 1;
        if (m_nacc == DEPTH) begin
          m_armed = 0;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
          m_cswait = 1;
`else
          m_done = 1;
`endif
        end
      end else if (m_cswait) begin
        if (rx_valid) begin
          m_cserr = (rx_data != m_sum);
          m_cswait = 0;
          m_done = 1;
        end
      end else if (m_armed) begin
        if (rx_valid) begin
          m_we = 1;
          m_addr = 16'(m_nacc);
          m_din = rx_data;
          m_sum = m_sum + rx_data;
          m_nacc = m_nacc + 1;
          m_gap = 1;
        end
      end else if (start) begin
        m_armed = 1; m_done = 0; m_nacc = 0; m_wcount = 0; m_sum = 0;
        m_over = 0; m_cserr = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) check("cycle_outputs", {20'd0, outvec}, {20'd0, expvec});

  logic [23:0] wq[$];
  always @(negedge clk) if (bram_we) wq.push_back({bram_addr, bram_din});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_start(input bit with_rv);
    start    = 1'b1;
    rx_valid = with_rv;
    rx_data  = 8'($urandom);
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", {20'd0, outvec}, 64'd0);
    #4 reset = 1'b1;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", {20'd0, outvec}, 64'd0);
    #2 reset = 1'b1;
    tick();

    pulse_start(0);
    wq.delete();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check("first_writes_n", wq.size(), 3);
    check("write0", wq[0], {16'd0, 8'h11});
    check("write1", wq[1], {16'd1, 8'h22});
    check("write2", wq[2], {16'd2, 8'h33});
    check("count3", image_write_count, 3);

    rx_valid = 1'b1;
    rx_data  = 8'h44;
    tick();
    rx_valid = 1'b0;
    check("last_we", {bram_we, bram_addr, bram_din}, {1'b1, 16'd3, 8'h44});
    check("complete_1cyc", bram_write_complete, 0);
    tick();
    check("count4", image_write_count, 4);
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    check("complete_in_check", bram_write_complete, 0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    tick();
    rx_valid = 1'b0;
    check("cs_good_complete", bram_write_complete, 1);
    check("cs_good_err", checksum_error, 0);
`else
    check("complete_2cyc", bram_write_complete, 1);
`endif
    send(8'h99);
    check("done_ignores_rx", wq.size(), 4);
    check("done_count", image_write_count, 4);

    pulse_start(0);
    check("rearm_complete", bram_write_complete, 0);
    check("rearm_count", image_write_count, 0);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    send(8'h0B);
    check("cs_bad_err", checksum_error, 1);
`endif
    check("frame2_complete", bram_write_complete, 1);
    check("frame2_writes_n", wq.size(), 8);
    check("frame2_first", wq[4], {16'd0, 8'h01});
    check("frame2_last", wq[7], {16'd3, 8'h04});

    pulse_start(0);
    check("rearm2_complete", bram_write_complete, 0);
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    check("rearm_cs_cleared", checksum_error, 0);
`endif
    wq.delete();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_data  = 8'h66;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    check("overrun_writes_n", wq.size(), 1);
    check("overrun_write", wq[0], {16'd0, 8'h55});
    check("overrun_flag", overrun_error, 1);
    check("overrun_count", image_write_count, 1);

    send(8'h12);
    check("mid_count", image_write_count, 2);
    async_reset();
    pulse_start(0);
    wq.delete();
    send(8'h77);
    check("post_reset_write", wq[0], {16'd0, 8'h77});
    check("post_reset_overrun", overrun_error, 0);

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 7) == 0) async_reset();
      pulse_start($urandom_range(0, 1) == 1);
      for (int k = 0; k < 8; k++) begin
        rx_data = 8'($urandom);
        if (m_cswait && $urandom_range(0, 1) == 1) rx_data = m_sum;
        rx_valid = 1'b1;
        start    = ($urandom_range(0, 9) == 0);
        tick();
        rx_valid = 1'b0;
        start    = 1'b0;
        if ($urandom_range(0, 7) != 0) repeat ($urandom_range(1, 3)) tick();
      end
      repeat (2) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
